// File: rtl/axi_master_pkg.sv
// Shared AXI B-channel constants and helpers for the master write-response tracker.
package axi_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int BREADY_MODE_USER = 0;
  localparam int BREADY_MODE_AUTO = 1;

  typedef logic [1:0] resp_t;

  function automatic logic resp_is_err(input resp_t resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_id_fifo.sv
// In-order FIFO of outstanding AXI write IDs; the caller qualifies push/pop, so a
// push and pop in the same cycle while full is legal and keeps the count unchanged.
module axi_id_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_push_id,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two; the count tells full from empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_id;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/axi_master_bresp_tracker.sv
// Tracks outstanding AXI writes from AW to B handshake: drives BREADY, retires responses
// in AW order with a registered report, flags ID/response errors, orphans and timeouts.
module axi_master_bresp_tracker
  import axi_master_pkg::*;
#(
  parameter int ID_W        = 12,
  parameter int MAX_OUTST   = 8,
  parameter int BREADY_MODE = 0,
  parameter int TIMEOUT     = 255,
  localparam int CW         = $clog2(MAX_OUTST) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_aw_fire,
  input  logic [ID_W-1:0] i_aw_id,
  input  logic            i_bready,
  input  logic            i_m_axi_bvalid,
  input  logic [ID_W-1:0] i_m_axi_bid,
  input  logic [1:0]      i_m_axi_bresp,
  output logic            o_m_axi_bready,
  output logic            o_resp_valid,
  output logic [ID_W-1:0] o_resp_id,
  output logic [1:0]      o_resp_code,
  output logic            o_resp_err,
  output logic            o_id_mismatch,
  output logic            o_orphan,
  output logic            o_overflow,
  output logic            o_timeout,
  output logic [CW-1:0]   o_outstanding,
  output logic            o_full
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [ID_W-1:0] w_head;
  logic [CW-1:0]   w_count;
  logic            w_full;
  logic            w_empty;
  logic            w_bready;
  logic            w_b_hs;
  logic            w_pop;
  logic            w_push;
  logic            w_id_mismatch;
  logic            w_timeout_hit;

  logic            r_resp_valid;
  logic [ID_W-1:0] r_resp_id;
  logic [1:0]      r_resp_code;
  logic            r_resp_err;
  logic            r_id_mismatch;
  logic            r_orphan;
  logic            r_overflow;
  logic            r_timeout;
  logic [7:0]      r_timer;

  axi_id_fifo #(
    .W     (ID_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (w_push),
    .i_push_id (i_aw_id),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_bready      = (BREADY_MODE == BREADY_MODE_AUTO) ? !w_empty : i_bready;
  assign w_b_hs        = i_m_axi_bvalid & w_bready;
  assign w_pop         = w_b_hs & !w_empty;
  // A pop in the same cycle frees the slot, so an AW while full is still accepted.
  assign w_push        = i_aw_fire & (!w_full | w_pop);
  assign w_id_mismatch = (i_m_axi_bid != w_head);
  assign w_timeout_hit = !w_empty & !w_pop & (r_timer == TIMEOUT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_resp_valid  <= 1'b0;
      r_resp_id     <= '0;
      r_resp_code   <= '0;
      r_resp_err    <= 1'b0;
      r_id_mismatch <= 1'b0;
      r_orphan      <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_resp_valid  <= w_pop;
      r_id_mismatch <= w_pop & w_id_mismatch;
      r_resp_err    <= w_pop & (resp_is_err(i_m_axi_bresp) | w_id_mismatch);
      if (w_pop) begin
        r_resp_id   <= i_m_axi_bid;
        r_resp_code <= i_m_axi_bresp;
      end
      r_orphan      <= w_b_hs & w_empty;
      r_timeout     <= w_timeout_hit;
      if (i_aw_fire & w_full & !w_pop) r_overflow <= 1'b1;
    end
  end

  // The timer passes TIMEOUT_LAST only once per clear, so the pulse cannot re-fire.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (w_empty | w_pop) begin
      r_timer <= '0;
    end else if (r_timer != 8'hFF) begin
      r_timer <= r_timer + 8'd1;
    end
  end

  assign o_m_axi_bready = w_bready;
  assign o_resp_valid   = r_resp_valid;
  assign o_resp_id      = r_resp_id;
  assign o_resp_code    = r_resp_code;
  assign o_resp_err     = r_resp_err;
  assign o_id_mismatch  = r_id_mismatch;
  assign o_orphan       = r_orphan;
  assign o_overflow     = r_overflow;
  assign o_timeout      = r_timeout;
  assign o_outstanding  = w_count;
  assign o_full         = w_full;

endmodule
